// File: rtl/coin_dispenser.sv
// Change-delivery back end: ejects one coin at a time, largest denomination first,
// with per-coin acknowledge, jam timeout and a configurable gap between coins.
//
// state | meaning
// IDLE  | waiting for a change request, req_ready high
// ISSUE | one eject line held high, waiting for eject_ack or timeout
// GAP   | all ejects low for GAP_CYCLES cycles before the next coin
// DONE  | one-cycle done pulse, results held until the next accept
module coin_dispenser #(
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_n25,
  input  logic [7:0]  req_n50,
  input  logic [7:0]  req_n100,
  output logic        eject_25,
  output logic        eject_50,
  output logic        eject_100,
  input  logic        eject_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rem_n25,
  output logic [7:0]  rem_n50,
  output logic [7:0]  rem_n100,
  output logic [15:0] value_dispensed
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic [2:0]  eject_q, eject_d;   // {100, 50, 25}, at most one bit set
  logic [7:0]  rem_n25_q, rem_n25_d;
  logic [7:0]  rem_n50_q, rem_n50_d;
  logic [7:0]  rem_n100_q, rem_n100_d;
  logic [15:0] value_q, value_d;
  logic        error_q, error_d;
  logic        done_q, done_d;

  logic [7:0]  left_n25, left_n50, left_n100;
  logic [15:0] coin_value;

  function automatic logic [2:0] pick(input logic [7:0] n25, input logic [7:0] n50,
                                      input logic [7:0] n100);
    if (n100 != 8'd0)     return 3'b100;
    else if (n50 != 8'd0) return 3'b010;
    else if (n25 != 8'd0) return 3'b001;
    else                  return 3'b000;
  endfunction

  // Counts left after the coin currently on the eject line is acknowledged.
  assign left_n25  = rem_n25_q  - {7'd0, eject_q[0]};
  assign left_n50  = rem_n50_q  - {7'd0, eject_q[1]};
  assign left_n100 = rem_n100_q - {7'd0, eject_q[2]};

  always_comb begin
    coin_value = 16'd0;
    if (eject_q[2])      coin_value = 16'd100;
    else if (eject_q[1]) coin_value = 16'd50;
    else if (eject_q[0]) coin_value = 16'd25;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    eject_d    = eject_q;
    rem_n25_d  = rem_n25_q;
    rem_n50_d  = rem_n50_q;
    rem_n100_d = rem_n100_q;
    value_d    = value_q;
    error_d    = error_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_n25_d  = req_n25;
          rem_n50_d  = req_n50;
          rem_n100_d = req_n100;
          value_d    = 16'd0;
          error_d    = 1'b0;
          timer_d    = 8'd0;
          gap_d      = 8'd0;
          eject_d    = pick(req_n25, req_n50, req_n100);
          if (pick(req_n25, req_n50, req_n100) == 3'b000) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // An ack on the timeout edge still counts as a delivered coin.
        if (eject_ack) begin
          rem_n25_d  = left_n25;
          rem_n50_d  = left_n50;
          rem_n100_d = left_n100;
          value_d    = value_q + coin_value;
          timer_d    = 8'd0;
          gap_d      = 8'd0;
          if (pick(left_n25, left_n50, left_n100) == 3'b000) begin
            eject_d = 3'b000;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            eject_d = pick(left_n25, left_n50, left_n100);
          end else begin
            eject_d = 3'b000;
            state_d = S_GAP;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          eject_d = 3'b000;
          error_d = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          timer_d = 8'd0;
          eject_d = pick(rem_n25_q, rem_n50_q, rem_n100_q);
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        eject_d = 3'b000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      gap_q      <= 8'd0;
      eject_q    <= 3'b000;
      rem_n25_q  <= 8'd0;
      rem_n50_q  <= 8'd0;
      rem_n100_q <= 8'd0;
      value_q    <= 16'd0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      eject_q    <= eject_d;
      rem_n25_q  <= rem_n25_d;
      rem_n50_q  <= rem_n50_d;
      rem_n100_q <= rem_n100_d;
      value_q    <= value_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign eject_100       = eject_q[2];
  assign eject_50        = eject_q[1];
  assign eject_25        = eject_q[0];
  assign done            = done_q;
  assign error           = error_q;
  assign rem_n25         = rem_n25_q;
  assign rem_n50         = rem_n50_q;
  assign rem_n100        = rem_n100_q;
  assign value_dispensed = value_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser: a default-parameter instance and a GAP_CYCLES=0
// instance, with coin order and transaction results checked from expectation queues.
module tb_coin_dispenser;

  typedef struct {
    int v;
    int r25;
    int r50;
    int r100;
    int e;
  } res_t;

  logic clock = 1'b0;
  logic reset_n;
  logic rv_a, rv_b;
  logic [7:0] req_n25, req_n50, req_n100;
  logic eject_ack;

  logic a_ready, a_e25, a_e50, a_e100, a_busy, a_done, a_error;
  logic [7:0] a_r25, a_r50, a_r100;
  logic [15:0] a_value;
  logic b_ready, b_e25, b_e50, b_e100, b_busy, b_done, b_error;
  logic [7:0] b_r25, b_r50, b_r100;
  logic [15:0] b_value;

  logic sel;
  logic o_ready, o_busy, o_done, o_error;
  logic [2:0] o_ej;
  logic [7:0] o_r25, o_r50, o_r100;
  logic [15:0] o_value;

  int n_tests = 0;
  int n_fail  = 0;
  int last_hi = 0;
  int coin_q[$];
  res_t res_q[$];

  always #5 clock = ~clock;

  coin_dispenser dut (
    .clock(clock), .reset_n(reset_n), .req_valid(rv_a), .req_ready(a_ready),
    .req_n25(req_n25), .req_n50(req_n50), .req_n100(req_n100),
    .eject_25(a_e25), .eject_50(a_e50), .eject_100(a_e100), .eject_ack(eject_ack),
    .busy(a_busy), .done(a_done), .error(a_error),
    .rem_n25(a_r25), .rem_n50(a_r50), .rem_n100(a_r100), .value_dispensed(a_value)
  );

  coin_dispenser #(.ACK_TIMEOUT(16), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv_b), .req_ready(b_ready),
    .req_n25(req_n25), .req_n50(req_n50), .req_n100(req_n100),
    .eject_25(b_e25), .eject_50(b_e50), .eject_100(b_e100), .eject_ack(eject_ack),
    .busy(b_busy), .done(b_done), .error(b_error),
    .rem_n25(b_r25), .rem_n50(b_r50), .rem_n100(b_r100), .value_dispensed(b_value)
  );

  always_comb begin
    if (sel) begin
      o_ready = b_ready; o_busy = b_busy; o_done = b_done; o_error = b_error;
      o_ej = {b_e100, b_e50, b_e25};
      o_r25 = b_r25; o_r50 = b_r50; o_r100 = b_r100; o_value = b_value;
    end else begin
      o_ready = a_ready; o_busy = a_busy; o_done = a_done; o_error = a_error;
      o_ej = {a_e100, a_e50, a_e25};
      o_r25 = a_r25; o_r50 = a_r50; o_r100 = a_r100; o_value = a_value;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int ej_val(input logic [2:0] e);
    case (e)
      3'b100:  return 100;
      3'b010:  return 50;
      3'b001:  return 25;
      3'b000:  return 0;
      default: return -1;
    endcase
  endfunction

  task automatic drive_valid(input logic v);
    if (sel) rv_b = v;
    else     rv_a = v;
  endtask

  // Drives a request and records the expected coin sequence (first ncoin coins) and result.
  task automatic start(input int n25, input int n50, input int n100, input int ncoin,
                       input int v, input int e25, input int e50, input int e100, input int err);
    int k = 0;
    res_t r;
    @(negedge clock);
    req_n25 = 8'(n25); req_n50 = 8'(n50); req_n100 = 8'(n100);
    drive_valid(1'b1);
    for (int i = 0; i < n100; i++) if (k < ncoin) begin coin_q.push_back(100); k++; end
    for (int i = 0; i < n50; i++)  if (k < ncoin) begin coin_q.push_back(50); k++; end
    for (int i = 0; i < n25; i++)  if (k < ncoin) begin coin_q.push_back(25); k++; end
    r.v = v; r.r25 = e25; r.r50 = e50; r.r100 = e100; r.e = err;
    res_q.push_back(r);
  endtask

  // Plays the coin mechanism until done (or until coin stop_coin rises).
  task automatic serve(input int ack_dly, input bit do_ack, input bit noise, input int stop_coin);
    int hi = 0, lows = 0, coins = 0, cyc = 0, cur, exp_c, exp_gap;
    bit fin = 0;
    res_t r;
    exp_gap = sel ? 0 : 2;
    last_hi = 0;
    while (!fin) begin
      @(negedge clock);
      cyc++;
      eject_ack = 1'b0;
      drive_valid(1'b0);
      cur = ej_val(o_ej);
      if (cyc == 1) begin
        chk("ready_low_busy", {31'd0, o_ready}, 0);
        chk("busy_high", {31'd0, o_busy}, 1);
      end
      if (cur == 0 && hi > 0) begin
        last_hi = hi;
        hi = 0;
        lows = 0;
      end
      if (cyc > 30000) begin
        chk("done_within_budget", {31'd0, o_done}, 1);
        fin = 1;
      end else if (o_done) begin
        fin = 1;
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("value_dispensed", {16'd0, o_value}, r.v);
          chk("rem_n25", {24'd0, o_r25}, r.r25);
          chk("rem_n50", {24'd0, o_r50}, r.r50);
          chk("rem_n100", {24'd0, o_r100}, r.r100);
          chk("error", {31'd0, o_error}, r.e);
          chk("eject_idle_at_done", {29'd0, o_ej}, 0);
        end else begin
          chk("unexpected_done", {31'd0, o_done}, 0);
        end
      end else if (cur != 0) begin
        if (hi == 0) begin
          coins++;
          exp_c = (coin_q.size() > 0) ? coin_q.pop_front() : 0;
          chk("coin_order", cur, exp_c);
          if (coins > 1) chk("gap_low_cycles", lows, exp_gap);
          if (coins == stop_coin) return;
        end
        hi++;
        if (do_ack && hi == ack_dly) begin
          eject_ack = 1'b1;
          hi = 0;
          lows = 0;
        end
      end else begin
        lows++;
        if (noise && coins > 0 && lows == 1) eject_ack = 1'b1;
      end
      if (noise && !o_done) begin
        req_n25 = 8'd3; req_n50 = 8'd0; req_n100 = 8'd0;
        drive_valid(cyc[0]);
      end
    end
    eject_ack = 1'b0;
    drive_valid(1'b0);
    @(negedge clock);
    chk("done_one_cycle", {31'd0, o_done}, 0);
    chk("ready_after_done", {31'd0, o_ready}, 1);
  endtask

  initial begin
    sel = 1'b0;
    reset_n = 1'b0;
    rv_a = 1'b0; rv_b = 1'b0;
    req_n25 = 8'd0; req_n50 = 8'd0; req_n100 = 8'd0;
    eject_ack = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", {31'd0, o_ready}, 1);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_eject", {29'd0, o_ej}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_error", {31'd0, o_error}, 0);
    chk("rst_value", {16'd0, o_value}, 0);
    chk("rst_rem", {8'd0, o_r25, o_r50, o_r100}, 0);

    // One of each denomination, acked two samples into each eject.
    start(1, 1, 1, 3, 175, 0, 0, 0, 0);
    serve(2, 1, 0, 0);

    // Empty request: straight to done.
    start(0, 0, 0, 0, 0, 0, 0, 0, 0);
    serve(2, 1, 0, 0);

    // Jam: no ack ever, the 50 line times out.
    start(0, 2, 0, 1, 0, 0, 2, 0, 1);
    serve(2, 0, 0, 0);
    chk("timeout_high_cycles", last_hi, 16);
    coin_q.delete();

    // Next accept clears the sticky error.
    start(1, 0, 0, 1, 25, 0, 0, 0, 0);
    serve(3, 1, 0, 0);

    // Request and ack noise while busy must not disturb the transaction.
    start(0, 1, 1, 2, 150, 0, 0, 0, 0);
    serve(2, 1, 1, 0);
    @(negedge clock);
    chk("noise_not_latched_busy", {31'd0, o_busy}, 0);

    // Reset while the second 100 is on the eject line.
    start(0, 0, 3, 3, 300, 0, 0, 0, 0);
    serve(2, 1, 0, 2);
    chk("pre_reset_eject", {29'd0, o_ej}, 3'b100);
    reset_n = 1'b0;
    #1;
    chk("reset_eject_async", {29'd0, o_ej}, 0);
    chk("reset_rem", {8'd0, o_r25, o_r50, o_r100}, 0);
    chk("reset_value", {16'd0, o_value}, 0);
    chk("reset_ready", {31'd0, o_ready}, 1);
    chk("reset_done", {31'd0, o_done}, 0);
    coin_q.delete();
    res_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    start(2, 0, 1, 3, 150, 0, 0, 0, 0);
    serve(1, 1, 0, 0);

    // Zero-gap instance, full load, acked as soon as each eject is seen.
    sel = 1'b1;
    start(255, 255, 255, 765, 44625, 0, 0, 0, 0);
    serve(1, 1, 0, 0);
    chk("coin_queue_drained", coin_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Change-delivery back end for the vending machine controller. Accepts one change request (coin count per denomination: 25, 50, 100) per transaction through a valid/ready handshake. Drives the coin ejector mechanism one coin at a time, largest denomination first, with a per-coin acknowledge, acknowledge timeout (jam detection) and inter-coin gap. Reports dispensed value, remaining counts, and completion/error status.

## Interface

Parameters:
- ACK_TIMEOUT, 16, max cycles an eject line stays high waiting for eject_ack; legal 1..255
- GAP_CYCLES, 2, idle cycles between consecutive ejects; legal 0..255

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  change request present
- req_ready  out  1  block can accept a request
- req_n25, req_n50, req_n100  in  8 each  coins of each denomination to dispense
- eject_25, eject_50, eject_100  out  1 each  eject command, at most one high, level held until ack or timeout
- eject_ack  in  1  mechanism confirms one coin delivered
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- error  out  1  jam occurred in last transaction; sticky until next accept
- rem_n25, rem_n50, rem_n100  out  8 each  coins not yet dispensed
- value_dispensed  out  16  value delivered in last/current transaction, in cents

## Operation

- States: IDLE, ISSUE, GAP, DONE. All outputs registered except req_ready = (state==IDLE) and busy = (state!=IDLE).
- Reset (async): state IDLE; eject_* 0, done 0, error 0, rem_* 0, value_dispensed 0, timer 0, gap counter 0. req_ready 1, busy 0.
- IDLE: on req_valid&req_ready edge, latch req_n* into rem_*, clear value_dispensed and error. If all three counts zero -> DONE; else -> ISSUE.
- ISSUE: assert eject for largest denomination with rem nonzero (100, then 50, then 25). Timer counts from 0 on entry.
  - eject_ack sampled high: decrement that rem, add 25/50/100 to value_dispensed, eject low from this edge. If all rem now zero -> DONE; else if GAP_CYCLES==0 -> ISSUE (fresh timer, next coin); else -> GAP.
  - No ack by edge where timer==ACK_TIMEOUT-1: eject low, error=1, -> DONE; rem_* retained.
  - Ack and timeout on same edge: ack wins.
- GAP: count GAP_CYCLES cycles, all ejects low, then -> ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE. rem_*, value_dispensed, error hold until next accept.
- eject_ack outside ISSUE ignored. req_valid outside IDLE ignored (not latched).
- Width: value_dispensed max 255*175 = 44625, no overflow in 16 bits. Timer and gap counter 8 bits, no wrap.

## Timing

- Accept at edge 0 -> eject high from edge 1.
- Eject high cycles = cycles until ack sampled, inclusive; max ACK_TIMEOUT.
- Ack at edge k, more coins: GAP_CYCLES>0 -> next eject high from edge k+GAP_CYCLES+1; GAP_CYCLES==0 -> next eject high from edge k+1 (one low cycle never inserted; line of same denomination stays high, treated as new coin).
- Last ack at edge k -> done high k+1..k+2 window (one cycle), req_ready high from edge k+2.
- Zero request accepted at edge 0 -> done high cycle after edge 1, req_ready at edge 2.
- Reset mid-transaction: ejects drop asynchronously; partial transaction discarded, no done pulse.

## Test plan

- Request 1x25, 1x50, 1x100, ack 2 cycles after each eject rises, defaults -> eject_100, eject_50, eject_25 in order, 2 low cycles between, value_dispensed 175, one done pulse, error 0, rem all 0.
- Request 0/0/0 -> no eject ever high, done one cycle later, value_dispensed 0.
- Request 2x50, eject_ack never asserted -> eject_50 high exactly 16 cycles, then error=1, done pulse, rem_n50=2, value_dispensed 0; next accept clears error.
- During busy toggle req_valid with 3x25 and pulse eject_ack during GAP -> request not latched, gap ack not counted, original totals unchanged.
- Request 3x100, assert reset_n low after first ack -> ejects 0 immediately, rem/value 0, req_ready 1; new request then completes normally.
- GAP_CYCLES=0, request 255 of each, ack same cycle eject seen high -> 765 coins, value_dispensed 44625, done once.
